// File: rtl/add_arbiter_pkg.sv
// Shared defaults and the requester-id width helper for add_arbiter.
package add_arbiter_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_DW    = 32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_arbiter_rr_arbiter.sv
// Round-robin grant logic: the search starts at 'pointer' and the first set req wins.
module rr_arbiter
    import add_arbiter_pkg::*;
#(
    parameter  int N_REQ = DEFAULT_N_REQ,
    localparam int IW    = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    pointer,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_valid
);

    logic [IW-1:0] idx;
    logic          found;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        idx     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        // Walk from the farthest offset back to the pointer so the nearest requester wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(pointer) + k) % N_REQ);
            if (req[idx]) begin
                gnt_idx = idx;
                found   = 1'b1;
            end
        end
        gnt_valid = found && enable;
        gnt       = '0;
        if (gnt_valid)
            gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin shared adder with a one-deep result register and valid/ready output.
// Define ADD_ARBITER_SATURATE_EN to clamp the sum to all-ones on carry instead of wrapping.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter  int N_REQ = DEFAULT_N_REQ,
    parameter  int DW    = DEFAULT_DW,
    localparam int IW    = id_width(N_REQ)
) (
    input  logic              okClk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*DW-1:0] op_a,
    input  logic [N_REQ*DW-1:0] op_b,
    output logic [N_REQ-1:0]  gnt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,
    output logic [IW-1:0]     res_id,
    output logic              res_ovf,
    output logic [31:0]       ops_count
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          enable;
    logic [DW:0]   sum;
    logic [DW-1:0] sum_data;
    logic [IW-1:0] ptr_next;
    logic [31:0]   ops_count_q;

    // No grants while the held result is blocked or while reset is asserted.
    assign enable = !(res_valid && !res_ready) && !reset;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (req),
        .pointer   (ptr_q),
        .enable    (enable),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign sum = {1'b0, op_a[int'(gnt_idx)*DW +: DW]} + {1'b0, op_b[int'(gnt_idx)*DW +: DW]};

`ifdef ADD_ARBITER_SATURATE_EN
    assign sum_data = sum[DW] ? '1 : sum[DW-1:0];
`else
    assign sum_data = sum[DW-1:0];
`endif

    assign ptr_next  = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    assign ops_count = ops_count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge okClk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_id      <= '0;
            res_ovf     <= 1'b0;
            ops_count_q <= '0;
        end else if (gnt_valid) begin
            ptr_q       <= ptr_next;
            res_valid   <= 1'b1;
            res_data    <= sum_data;
            res_id      <= gnt_idx;
            res_ovf     <= sum[DW];
            ops_count_q <= ops_count_q + 32'd1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed cases plus randomized traffic against a behavioural model.
module tb_add_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            okClk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] op_a;
    logic [N*DW-1:0] op_b;
    logic [N-1:0]    gnt;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_data;
    logic [1:0]      res_id;
    logic            res_ovf;
    logic [31:0]     ops_count;

    add_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .okClk     (okClk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .ops_count (ops_count)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the result port should show, plus the next search start.
    int          m_start;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_id;
    logic        m_ovf;
    logic [31:0] m_count;

    logic [31:0] a_v [N];
    logic [31:0] b_v [N];
    bit          pend [N];
    int          last_pick;
    logic [N-1:0] obs_gnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_start = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ovf   = 1'b0;
        m_count = '0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, ".res_valid"}, 64'(res_valid), 64'(m_valid));
        check({pfx, ".res_data"},  64'(res_data),  64'(m_data));
        check({pfx, ".res_id"},    64'(res_id),    64'(m_id));
        check({pfx, ".res_ovf"},   64'(res_ovf),   64'(m_ovf));
        check({pfx, ".ops_count"}, 64'(ops_count), 64'(m_count));
    endtask

    // One clock: drive at negedge, check the combinational grant and registered outputs, then advance the model.
    task automatic step(input logic [N-1:0] r, input logic rdy);
        int pick;
        logic [32:0] s;
        @(negedge okClk);
        req       = r;
        res_ready = rdy;
        for (int i = 0; i < N; i++) begin
            op_a[i*DW +: DW] = a_v[i];
            op_b[i*DW +: DW] = b_v[i];
        end
        #1;
        pick = (m_valid && !rdy) ? -1 : model_pick(r, m_start);
        obs_gnt = gnt;
        check("gnt", 64'(gnt), (pick >= 0) ? (64'd1 << pick) : 64'd0);
        check_outputs("out");
        @(posedge okClk);
        if (pick >= 0) begin
            s = {1'b0, a_v[pick]} + {1'b0, b_v[pick]};
`ifdef ADD_ARBITER_SATURATE_EN
            m_data = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
            m_data = s[31:0];
`endif
            m_ovf   = s[32];
            m_id    = pick;
            m_valid = 1'b1;
            m_start = (pick + 1) % N;
            m_count = m_count + 32'd1;
        end else if (rdy && m_valid) begin
            m_valid = 1'b0;
        end
        last_pick = pick;
    endtask

    task automatic pulse_reset();
        @(negedge okClk);
        reset = 1'b1;
        req   = '1;
        #1;
        model_reset();
        check("rst.gnt", 64'(gnt), 64'd0);
        check_outputs("rst");
        @(posedge okClk);
        @(negedge okClk);
        reset = 1'b0;
        req   = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req       = '0;
        res_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        for (int i = 0; i < N; i++) begin
            a_v[i] = 32'(i + 1);
            b_v[i] = 32'(10 * (i + 1));
            pend[i] = 1'b0;
        end
        model_reset();
        pulse_reset();

        // Single request, simple sum with latency 1.
        a_v[0] = 32'd3; b_v[0] = 32'd4;
        step(4'b0001, 1'b1);
        check("basic.gnt", 64'(obs_gnt), 64'b0001);
        step(4'b0000, 1'b1);
        check("basic.data", 64'(res_data), 64'd7);
        check("basic.valid", 64'(res_valid), 64'd1);

        // All four requesting: strict rotation from requester 0.
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b1);
            check("rr.order", 64'(obs_gnt), 64'd1 << (i % 4));
        end
        @(negedge okClk); #1;
        check("rr.count", 64'(ops_count), 64'd8);

        // Carry out of the top bit.
        pulse_reset();
        a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'd2;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
`ifdef ADD_ARBITER_SATURATE_EN
        check("ovf.data", 64'(res_data), 64'hFFFF_FFFF);
`else
        check("ovf.data", 64'(res_data), 64'h0000_0001);
`endif
        check("ovf.flag", 64'(res_ovf), 64'd1);

        // Backpressure: held result blocks new grants until ready.
        pulse_reset();
        a_v[0] = 32'd3; b_v[0] = 32'd4;
        a_v[1] = 32'd100; b_v[1] = 32'd23;
        step(4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 1'b0);
            check("stall.gnt", 64'(obs_gnt), 64'd0);
            check("stall.data", 64'(res_data), 64'd7);
        end
        step(4'b0010, 1'b1);
        check("unstall.gnt", 64'(obs_gnt), 64'b0010);
        @(negedge okClk); #1;
        check("unstall.data", 64'(res_data), 64'd123);
        check("unstall.id", 64'(res_id), 64'd1);

        // Reset while a result is held and the pointer sits at 2.
        pulse_reset();
        step(4'b1100, 1'b1);
        check("postrst.gnt", 64'(obs_gnt), 64'b0100);

        // Counter wrap from all-ones.
        step(4'b0000, 1'b1);
        #2;
        force dut.ops_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.ops_count_q;
        m_count = 32'hFFFF_FFFF;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        check("wrap.count", 64'(ops_count), 64'd0);

        // Randomized traffic: requesters hold until granted, operands stable while pending.
        pulse_reset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] r;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    a_v[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    b_v[i] = $urandom;
                end
                r[i] = pend[i];
            end
            step(r, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            if (last_pick >= 0) pend[last_pick] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
